// File: rtl/logunit_if.sv
// Valid/ready stream bundle for the logunit: fp16 operand in, fp16 ln(a) plus {invalid, divzero} out.
interface logunit_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [1:0]  flags;

    modport master (output in_valid, a, out_ready, input in_ready, out_valid, z, flags);
    modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, z, flags);
endinterface

// File: rtl/logunit.sv
// logunit: pipelined fp16 z = ln(a) as e*ln2 + table ln(1.m); LOGUNIT_INTERP_EN adds linear interpolation.
// Latency 3 cycles from accept to out_valid, one operand per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready = ~out_valid | out_ready.
module logunit #(
    parameter int          ACC_W   = 22,
    parameter logic [15:0] LN2_Q16 = 16'd45426
) (
    input  logic     clk,
    input  logic     reset,
    logunit_if.slave io
);
    localparam int KW = $clog2(ACC_W);
    localparam logic signed [ACC_W-1:0] LN2_W = $signed(ACC_W'(LN2_Q16));

    logic adv;
    assign adv         = ~io.out_valid | io.out_ready;
    assign io.in_ready = adv;

    function automatic logic [15:0] ln_tab(input logic [4:0] k);
        case (k)
            5'd0:    ln_tab = 16'd0;
            5'd1:    ln_tab = 16'd3973;
            5'd2:    ln_tab = 16'd7719;
            5'd3:    ln_tab = 16'd11262;
            5'd4:    ln_tab = 16'd14624;
            5'd5:    ln_tab = 16'd17821;
            5'd6:    ln_tab = 16'd20870;
            5'd7:    ln_tab = 16'd23783;
            5'd8:    ln_tab = 16'd26573;
            5'd9:    ln_tab = 16'd29248;
            5'd10:   ln_tab = 16'd31818;
            5'd11:   ln_tab = 16'd34292;
            5'd12:   ln_tab = 16'd36675;
            5'd13:   ln_tab = 16'd38975;
            5'd14:   ln_tab = 16'd41196;
            5'd15:   ln_tab = 16'd43345;
            default: ln_tab = 16'd45426;
        endcase
    endfunction

    // S1 decode: operands that never reach the fixed-point path are resolved here.
    logic        a_s;
    logic [4:0]  a_e;
    logic [9:0]  a_m;
    logic        d_spc;
    logic [15:0] d_z;
    logic [1:0]  d_fl;

    assign a_s = io.a[15];
    assign a_e = io.a[14:10];
    assign a_m = io.a[9:0];

    always_comb begin
        d_spc = 1'b0;
        d_z   = 16'h7E00;
        d_fl  = 2'b10;
        if (a_e == 5'd0) begin
            d_spc = 1'b1;
            d_z   = 16'hFC00;
            d_fl  = 2'b01;
        end else if (a_s || (a_e == 5'd31 && a_m != 10'd0)) begin
            d_spc = 1'b1;
        end else if (a_e == 5'd31) begin
            d_spc = 1'b1;
            d_z   = 16'h7C00;
            d_fl  = 2'b00;
        end
    end

    logic               v1, v2, v3;
    logic               s1_spc, s2_spc, s3_spc;
    logic [15:0]        s1_z, s2_z, s3_z;
    logic [1:0]         s1_fl, s2_fl, s3_fl;
    logic signed [5:0]  s1_e;
    logic [3:0]         s1_i;
`ifdef LOGUNIT_INTERP_EN
    logic [5:0]         s1_f;
`endif
    logic signed [ACC_W-1:0] s2_sum;
    logic               s3_sgn;
    logic [ACC_W-1:0]   s3_mag;
    logic [KW-1:0]      s3_k;

    // S2 evaluation: lnm = ln(1.m) in Q16, plus e*ln2.
    logic [16:0] lnm;
`ifdef LOGUNIT_INTERP_EN
    logic [15:0] l_lo, l_hi, l_dif;
    logic [21:0] l_prd;
    always_comb begin
        l_lo  = ln_tab({1'b0, s1_i});
        l_hi  = ln_tab({1'b0, s1_i} + 5'd1);
        l_dif = l_hi - l_lo;
        l_prd = {6'd0, l_dif} * {16'd0, s1_f};
        lnm   = {1'b0, l_lo} + 17'(l_prd >> 6);
    end
`else
    assign lnm = {1'b0, ln_tab({1'b0, s1_i})};
`endif

    logic signed [ACC_W-1:0] e_w, p, sum_d;
    assign e_w   = ACC_W'(s1_e);
    assign p     = e_w * LN2_W;
    assign sum_d = p + $signed(ACC_W'(lnm));

    // S3: magnitude and leading-one position, then normalise into fp16.
    logic [ACC_W-1:0] mag_d;
    logic [KW-1:0]    k_d;
    always_comb begin
        mag_d = s2_sum[ACC_W-1] ? $unsigned(-s2_sum) : $unsigned(s2_sum);
        k_d   = '0;
        for (int b = 0; b < ACC_W; b++) begin
            if (mag_d[b]) k_d = KW'(b);
        end
    end

    logic [9:0]  mant;
    logic [15:0] z_d;
    always_comb begin
        mant = (s3_k >= KW'(10)) ? 10'(s3_mag >> (s3_k - KW'(10)))
                                 : 10'(s3_mag << (KW'(10) - s3_k));
        if (s3_spc)
            z_d = s3_z;
        else if (s3_k < KW'(2))
            z_d = {s3_sgn, 15'd0};
        else
            z_d = {s3_sgn, 5'(s3_k - KW'(1)), mant};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            io.out_valid <= 1'b0;
            io.z         <= 16'h0000;
            io.flags     <= 2'b00;
        end else if (adv) begin
            v1           <= io.in_valid;
            v2           <= v1;
            v3           <= v2;
            io.out_valid <= v3;
            if (v3) begin
                io.z     <= z_d;
                io.flags <= s3_spc ? s3_fl : 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            if (io.in_valid) begin
                s1_spc <= d_spc;
                s1_z   <= d_z;
                s1_fl  <= d_fl;
                s1_e   <= $signed({1'b0, a_e}) - 6'sd15;
                s1_i   <= a_m[9:6];
`ifdef LOGUNIT_INTERP_EN
                s1_f   <= a_m[5:0];
`endif
            end
            s2_spc <= s1_spc;
            s2_z   <= s1_z;
            s2_fl  <= s1_fl;
            s2_sum <= sum_d;
            s3_spc <= s2_spc;
            s3_z   <= s2_z;
            s3_fl  <= s2_fl;
            s3_sgn <= s2_sum[ACC_W-1];
            s3_mag <= mag_d;
            s3_k   <= k_d;
        end
    end
endmodule

// File: doc/logunit.md
# logunit

Pipelined fp16 natural-logarithm unit for the softmax datapath: the inverse of the exponential unit. It computes z = ln(a) for log-softmax and log-sum-exp paths. It decodes an fp16 operand into unbiased exponent and mantissa, then evaluates e·ln2 + ln(1.m) in signed fixed point using a 17-entry table with linear interpolation. A fixed-to-fp16 converter produces the result. It sits between the accumulator's sum output and the log-softmax subtract stage, with a valid/ready stream on both sides.

## Interface
- LN2_Q16, 45426: ln2 in Q0.16.
- ACC_W, 22: signed width of the fixed-point sum, with 16 fraction bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand `a` is valid.
- in_ready  out  1  unit accepts an operand this cycle.
- a  in  16  fp16 operand.
- out_valid  out  1  result `z` is valid.
- out_ready  in  1  downstream accepts the result.
- z  out  16  fp16 ln(a).
- flags  out  2  {invalid, divzero}; qualified by out_valid.

## Operation
- Stage S1 (decode):
  - sign s = a[15], E = a[14:10], M = a[9:0].
  - Unbiased exponent e = E − 15, signed 6-bit.
  - Table index i = M[9:6]; interpolation fraction f = M[5:0].
  - Special class is registered alongside the decoded fields.
- Special cases, resolved in S1 and carried through S2/S3 unchanged:
  - E=0, any M (zero or subnormal, either sign): z=0xFC00, divzero=1.
  - s=1 and a is nonzero normal or inf: z=0x7E00, invalid=1.
  - E=31 and M≠0 (NaN): z=0x7E00, invalid=1.
  - a=0x7C00: z=0x7C00, flags=0.
- Table: L[k] = round(ln(1+k/16)·2^16) for k=0..16, unsigned 16-bit. L[0]=0, L[16]=45426.
- Stage S2 (fixed-point evaluation):
  - lnm = L[i] + ((L[i+1]−L[i])·f >> 6), where >> truncates.
  - p = e·LN2_Q16, signed.
  - sum = p + lnm, signed ACC_W bits; all intermediate values fit without overflow.
- Stage S3 (fixed → fp16):
  - Take the magnitude of sum and detect the leading one at bit position k.
  - Output exponent = k − 16 + 15.
  - Mantissa = the 10 bits below the leading one, truncated (round toward zero); zero-padded if k<10.
  - Output sign = sign of sum.
  - sum=0 → z=0x0000.
  - Magnitude < 2^-14 → flushed to signed zero.
- Results leave in input order. No reordering and no drops.

## Timing
- Latency is 3 cycles. An operand accepted at edge n (in_valid & in_ready) has out_valid high after edge n+3, provided there is no stall.
- Throughput is 1 operand per cycle.
- in_ready = ~out_valid | out_ready.
- When out_valid & ~out_ready, all three stages hold: registers, valid bits, z and flags are frozen and stable.
- If the pipe is stalled while S1/S2 bubbles are empty, those bubbles still hold. Only a full pass-through condition advances the pipe.
- Simultaneous acceptance and output handoff in the same cycle is legal and sustains full throughput.
- Reset:
  - Clears all stage valid bits.
  - z=0x0000, flags=2'b00, out_valid=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-stream discards all in-flight operands, with no output for them.
- in_valid must not depend on in_ready. Data `a` is sampled only on handshake.

## Configuration
- LOGUNIT_INTERP_EN defined: linear interpolation as specified; one 16×6 multiplier in S2.
- LOGUNIT_INTERP_EN undefined: lnm = L[i]; f is ignored and there is no multiplier. Latency, handshake, special cases and results for operands with M[5:0]=0 are identical in both builds.

## Test plan
- After reset, drive a=0x3C00, 0x4000, 0x3800 back-to-back with out_ready=1. Expect z=0x0000, 0x398B, 0xB98B on three consecutive cycles starting 3 cycles after the first accept, with flags=0.
- a=0x0000, 0x0001, 0xBC00, 0x7E00, 0x7C00 → z=0xFC00/divzero, 0xFC00/divzero, 0x7E00/invalid, 0x7E00/invalid, 0x7C00/flags=0.
- Backpressure: stream 8 operands while holding out_ready=0 for 5 cycles mid-stream. Expect in_ready to drop, z to stay frozen while stalled, and all 8 results in order with none lost or duplicated.
- a=0x3C40 (1.0625, i=1, f=0) → sum=L[1]=3973 → z=0x2BC2. Identical with and without LOGUNIT_INTERP_EN.
- Interpolation: a=0x3C20 (i=0, f=32). With the macro: sum=1986 → z=0x27C2. Without the macro: z=0x0000.
- Assert reset with 3 operands in flight. Expect no out_valid in the following cycles and z=0x0000; a new operand then returns its result after exactly 3 cycles.
